// File: rtl/quicksort_ctrl_if.sv
// Bundle between the quicksort sequencer, its requester and the Lomuto partition stage.
// master = sequencer side, slave = requester/partition side.
interface quicksort_ctrl_if #(
  parameter int ARR_WIDTH = 4,
  parameter int DATA_W    = 4,
  parameter int IDX_W     = 2
);
  logic                        start;
  logic [ARR_WIDTH*DATA_W-1:0] array_in;
  logic                        busy;
  logic                        done;
  logic                        error;
  logic [ARR_WIDTH*DATA_W-1:0] array_out;
  logic                        part_start;
  logic [IDX_W-1:0]            part_lo;
  logic [IDX_W-1:0]            part_hi;
  logic [ARR_WIDTH*DATA_W-1:0] part_array;
  logic                        part_ready;
  logic [ARR_WIDTH*DATA_W-1:0] part_array_in;
  logic [IDX_W-1:0]            part_pivot_idx;

  modport master (
    input  start, array_in, part_ready, part_array_in, part_pivot_idx,
    output busy, done, error, array_out, part_start, part_lo, part_hi, part_array
  );

  modport slave (
    output start, array_in, part_ready, part_array_in, part_pivot_idx,
    input  busy, done, error, array_out, part_start, part_lo, part_hi, part_array
  );
endinterface

// File: rtl/quicksort_ctrl.sv
// Quicksort sequencer: owns the working array and a (lo, hi) range stack, drives one
// partition per range. Optional partition watchdog enabled by macro QS_PART_TIMEOUT_EN.
module quicksort_ctrl #(
  parameter int ARR_WIDTH   = 4,
  parameter int DATA_W      = 4,
  parameter int IDX_W       = 2,
  parameter int STACK_DEPTH = 4,
  parameter int TIMEOUT     = 255
) (
  input logic clock,
  input logic reset,
  quicksort_ctrl_if.master bus
);
  localparam int W    = ARR_WIDTH * DATA_W;
  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam int SA_W = $clog2(STACK_DEPTH);
  localparam int E_W  = IDX_W + 1;

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {IDLE, INIT, POP, LAUNCH, WAIT, SPLIT, FINISH} state_t;

  state_t           state;
  logic [SP_W-1:0]  sp;
  logic [IDX_W-1:0] stk_lo [STACK_DEPTH];
  logic [IDX_W-1:0] stk_hi [STACK_DEPTH];
  logic [IDX_W-1:0] lo_r, hi_r, pivot;
  logic [IDX_W-1:0] pend_lo, pend_hi;
  logic [W-1:0]     arr;
  logic             busy_r, done_r, err_r, pstart_r;
  logic             split_ph;
`ifdef QS_PART_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt;
`endif

  logic [SA_W-1:0]  sp_top;
  logic [E_W-1:0]   lo_e, hi_e, p_e, left_len, right_len;
  logic             left_ok, right_ok, left_first;
  logic [IDX_W-1:0] left_hi, right_lo;
  logic             push_en, second, overflow;
  logic [IDX_W-1:0] push_lo, push_hi;

  assign sp_top = SA_W'(sp - 1'b1);

  // Sub-range selection; widened by one bit so p-1 / p+2 cannot wrap
  always_comb begin
    lo_e       = {1'b0, lo_r};
    hi_e       = {1'b0, hi_r};
    p_e        = {1'b0, pivot};
    left_len   = p_e - lo_e;
    right_len  = hi_e - p_e;
    left_ok    = (p_e >= lo_e + E_W'(2));
    right_ok   = (p_e + E_W'(2) <= hi_e);
    left_first = (left_len >= right_len);
    left_hi    = IDX_W'(p_e - E_W'(1));
    right_lo   = IDX_W'(p_e + E_W'(1));
  end

  always_comb begin
    push_en = 1'b0;
    push_lo = '0;
    push_hi = '0;
    second  = 1'b0;
    case (state)
      INIT: begin
        push_en = 1'b1;
        push_hi = IDX_W'(ARR_WIDTH - 1);
      end
      SPLIT: begin
        if (split_ph) begin
          push_en = 1'b1;
          push_lo = pend_lo;
          push_hi = pend_hi;
        end else if (left_ok && (!right_ok || left_first)) begin
          push_en = 1'b1;
          push_lo = lo_r;
          push_hi = left_hi;
          second  = right_ok;
        end else if (right_ok) begin
          push_en = 1'b1;
          push_lo = right_lo;
          push_hi = hi_r;
          second  = left_ok;
        end
      end
      default: ;
    endcase
  end

  assign overflow = push_en && (sp == SP_W'(STACK_DEPTH));

  // Stack storage carries no reset; the pointer alone defines validity
  always_ff @(posedge clock) begin
    if (push_en && !overflow) begin
      stk_lo[SA_W'(sp)] <= push_lo;
      stk_hi[SA_W'(sp)] <= push_hi;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      sp       <= '0;
      lo_r     <= '0;
      hi_r     <= '0;
      pivot    <= '0;
      pend_lo  <= '0;
      pend_hi  <= '0;
      arr      <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      pstart_r <= 1'b0;
      split_ph <= 1'b0;
`ifdef QS_PART_TIMEOUT_EN
      cnt      <= '0;
`endif
    end else begin
      pstart_r <= 1'b0;
      done_r   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            arr    <= bus.array_in;
            err_r  <= 1'b0;
            busy_r <= 1'b1;
            sp     <= '0;
            state  <= INIT;
          end
        end
        INIT, SPLIT: begin
          if (overflow) begin
            err_r  <= 1'b1;
            done_r <= 1'b1;
            busy_r <= 1'b0;
            state  <= FINISH;
          end else begin
            if (push_en) sp <= sp + 1'b1;
            if (second) begin
              split_ph <= 1'b1;
              pend_lo  <= left_first ? right_lo : lo_r;
              pend_hi  <= left_first ? hi_r : left_hi;
            end else begin
              split_ph <= 1'b0;
              state    <= POP;
            end
          end
        end
        POP: begin
          if (sp == '0) begin
            done_r <= 1'b1;
            busy_r <= 1'b0;
            state  <= FINISH;
          end else begin
            lo_r <= stk_lo[sp_top];
            hi_r <= stk_hi[sp_top];
            sp   <= sp - 1'b1;
            if (stk_lo[sp_top] < stk_hi[sp_top]) begin
              pstart_r <= 1'b1;
              state    <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
`ifdef QS_PART_TIMEOUT_EN
          cnt   <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          if (bus.part_ready) begin
            arr      <= bus.part_array_in;
            pivot    <= bus.part_pivot_idx;
            split_ph <= 1'b0;
            state    <= SPLIT;
          end
`ifdef QS_PART_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            err_r  <= 1'b1;
            done_r <= 1'b1;
            busy_r <= 1'b0;
            state  <= FINISH;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.error      = err_r;
  assign bus.array_out  = arr;
  assign bus.part_array = arr;
  assign bus.part_start = pstart_r;
  assign bus.part_lo    = lo_r;
  assign bus.part_hi    = hi_r;
endmodule

// File: tb/tb_quicksort_ctrl.sv
// Directed bench for quicksort_ctrl with a 3-cycle Lomuto partition model.
module tb_quicksort_ctrl;
  localparam int AW = 4;
  localparam int DW = 4;
  localparam int IW = 2;
`ifdef QS_PART_TIMEOUT_EN
  localparam int TB_TO = 8;
`else
  localparam int TB_TO = 255;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  quicksort_ctrl_if #(.ARR_WIDTH(AW), .DATA_W(DW), .IDX_W(IW)) bus ();

  quicksort_ctrl #(
    .ARR_WIDTH(AW), .DATA_W(DW), .IDX_W(IW), .STACK_DEPTH(4), .TIMEOUT(TB_TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.master)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Partition model state
  bit model_en = 1'b1;
  bit spurious = 1'b0;
  int gen = 0;
  int n_starts = 0;
  int log_lo [16];
  int log_hi [16];

  // Sort results
  bit          r_ok;
  bit          r_busy_run;
  logic        r_busy_done;
  int          r_extra;
  logic [15:0] r_arr;

  typedef struct {
    logic [15:0] in;
    logic [15:0] exp;
    int          starts;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void lomuto(input logic [15:0] a_in, input int lo, input int hi,
                                 output logic [15:0] a_out, output int p);
    logic [3:0] a [4];
    logic [3:0] t;
    logic [3:0] pv;
    int i;
    for (int k = 0; k < 4; k++) a[k] = a_in[k*4 +: 4];
    pv = a[hi];
    i = lo;
    for (int j = lo; j < hi; j++) begin
      if (a[j] < pv) begin
        t = a[i]; a[i] = a[j]; a[j] = t;
        i++;
      end
    end
    t = a[i]; a[i] = a[hi]; a[hi] = t;
    p = i;
    for (int k = 0; k < 4; k++) a_out[k*4 +: 4] = a[k];
  endfunction

  initial begin : part_model
    logic [15:0] res;
    int p, my_gen;
    bus.part_ready = 1'b0;
    bus.part_array_in = '0;
    bus.part_pivot_idx = '0;
    forever begin
      @(negedge clock);
      if (reset && bus.part_start) begin
        if (n_starts < 16) begin
          log_lo[n_starts] = int'(bus.part_lo);
          log_hi[n_starts] = int'(bus.part_hi);
        end
        n_starts++;
        if (model_en) begin
          my_gen = gen;
          lomuto(bus.part_array, int'(bus.part_lo), int'(bus.part_hi), res, p);
          if (spurious) begin
            bus.part_array_in = 16'hFFFF;
            bus.part_pivot_idx = '0;
            bus.part_ready = 1'b1;
            @(negedge clock);
            bus.part_ready = 1'b0;
            @(negedge clock);
          end else begin
            repeat (2) @(negedge clock);
          end
          if (my_gen == gen) begin
            bus.part_array_in = res;
            bus.part_pivot_idx = IW'(p);
            bus.part_ready = 1'b1;
            @(negedge clock);
            bus.part_ready = 1'b0;
          end
        end
      end
    end
  end

  task automatic run_sort(input logic [15:0] a, input bit hold);
    int lat;
    n_starts = 0;
    r_ok = 1'b0;
    r_extra = 0;
    @(negedge clock);
    bus.array_in = a;
    bus.start = 1'b1;
    @(negedge clock);
    if (!hold) bus.start = 1'b0;
    r_busy_run = bus.busy;
    lat = 0;
    while (lat < 400 && !r_ok) begin
      if (bus.done) r_ok = 1'b1;
      else begin
        @(negedge clock);
        lat++;
      end
    end
    bus.start = 1'b0;
    r_busy_done = bus.busy;
    r_arr = bus.array_out;
    repeat (10) begin
      @(negedge clock);
      if (bus.done) r_extra++;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench watchdog expired");
  end

  initial begin : main
    vec_t vecs [5];
    int seen, t0, lat;
    bit got;

    vecs[0] = '{16'h0213, 16'h3210, 3};
    vecs[1] = '{16'h3210, 16'h3210, 3};
    vecs[2] = '{16'h5555, 16'h5555, 3};
    vecs[3] = '{16'h0123, 16'h3210, -1};
    vecs[4] = '{16'h9F3A, 16'hFA93, -1};

    bus.start = 1'b0;
    bus.array_in = '0;
    repeat (3) @(negedge clock);
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset error", bus.error, 0);
    check("reset part_start", bus.part_start, 0);
    check("reset part_lo", bus.part_lo, 0);
    check("reset part_hi", bus.part_hi, 0);
    check("reset array_out", bus.array_out, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 5; i++) begin
      run_sort(vecs[i].in, 1'b0);
      check($sformatf("vec%0d done seen", i), r_ok, 1);
      check($sformatf("vec%0d busy running", i), r_busy_run, 1);
      check($sformatf("vec%0d array_out", i), r_arr, vecs[i].exp);
      check($sformatf("vec%0d busy at done", i), r_busy_done, 0);
      check($sformatf("vec%0d error", i), bus.error, 0);
      check($sformatf("vec%0d extra done", i), r_extra, 0);
      if (vecs[i].starts >= 0)
        check($sformatf("vec%0d part_start count", i), n_starts, vecs[i].starts);
    end

    // Already-sorted input: launch ranges in order
    run_sort(16'h3210, 1'b0);
    check("sorted starts", n_starts, 3);
    check("sorted r0 lo", log_lo[0], 0);
    check("sorted r0 hi", log_hi[0], 3);
    check("sorted r1 lo", log_lo[1], 0);
    check("sorted r1 hi", log_hi[1], 2);
    check("sorted r2 lo", log_lo[2], 0);
    check("sorted r2 hi", log_hi[2], 1);

    // start held high throughout the sort
    run_sort(16'h0213, 1'b1);
    check("hold array_out", r_arr, 16'h3210);
    check("hold starts", n_starts, 3);
    check("hold extra done", r_extra, 0);
    check("hold busy after", bus.busy, 0);

    // Garbage part_ready asserted during LAUNCH
    spurious = 1'b1;
    run_sort(16'h0123, 1'b0);
    spurious = 1'b0;
    check("spurious array_out", r_arr, 16'h3210);
    check("spurious done seen", r_ok, 1);

    // Asynchronous reset while waiting on the partition stage
    n_starts = 0;
    @(negedge clock);
    bus.array_in = 16'h0213;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    seen = 0;
    while (seen < 50 && n_starts == 0) begin
      @(negedge clock);
      seen++;
    end
    check("midreset launch seen", (n_starts > 0), 1);
    @(negedge clock);
    check("midreset busy before", bus.busy, 1);
    #2;
    reset = 1'b0;
    gen++;
    #1;
    check("midreset busy", bus.busy, 0);
    check("midreset done", bus.done, 0);
    check("midreset part_start", bus.part_start, 0);
    check("midreset error", bus.error, 0);
    @(negedge clock);
    reset = 1'b1;
    n_starts = 0;
    repeat (10) @(negedge clock);
    check("midreset no relaunch", n_starts, 0);
    run_sort(16'h0213, 1'b0);
    check("post reset array_out", r_arr, 16'h3210);
    check("post reset done seen", r_ok, 1);

`ifdef QS_PART_TIMEOUT_EN
    // Partition stage never answers
    model_en = 1'b0;
    @(negedge clock);
    bus.array_in = 16'h0213;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    seen = 0;
    got = 1'b0;
    t0 = 0;
    while (seen < 50 && !got) begin
      if (bus.part_start) begin
        got = 1'b1;
        t0 = cyc;
      end else begin
        @(negedge clock);
        seen++;
      end
    end
    check("timeout launch seen", got, 1);
    got = 1'b0;
    lat = 0;
    seen = 0;
    while (seen < 50 && !got) begin
      @(negedge clock);
      seen++;
      if (bus.done) begin
        got = 1'b1;
        lat = cyc - t0;
      end
    end
    check("timeout done seen", got, 1);
    check("timeout latency", lat, 9);
    check("timeout error", bus.error, 1);
    model_en = 1'b1;
    repeat (3) @(negedge clock);
    run_sort(16'h0213, 1'b0);
    check("after timeout array_out", r_arr, 16'h3210);
    check("after timeout error cleared", bus.error, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/quicksort_ctrl.md
Name: quicksort_ctrl

Overview:
- Top-level sequencer for the hardware quicksort.
- Sits directly upstream of the Lomuto partition stage. It owns the working array and a (lo, hi) range stack, launches one partition per sub-range via a start/ready handshake, and consumes the returned pivot index to schedule the sub-ranges.
- Emits the sorted array with a one-cycle done pulse.

Parameters:
- ARR_WIDTH, 4: number of array elements.
- DATA_W, 4: bits per element; element k is packed at [k*DATA_W +: DATA_W].
- IDX_W, 2: index width, equal to clog2(ARR_WIDTH).
- STACK_DEPTH, 4: range-stack entries.
- TIMEOUT, 255: partition watchdog limit in cycles; used only with the optional feature.

Ports:
- clock, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- start, input, 1: sort request; sampled only in IDLE.
- array_in, input, ARR_WIDTH*DATA_W: unsorted array; captured on an accepted start.
- busy, output, 1: high from the cycle after an accepted start until done.
- done, output, 1: one-cycle pulse when array_out is valid.
- error, output, 1: sticky; set on stack overflow or timeout; cleared on the next accepted start.
- array_out, output, ARR_WIDTH*DATA_W: working/sorted array register.
- part_start, output, 1: one-cycle launch pulse to the partition stage.
- part_lo, output, IDX_W: low index of the current range.
- part_hi, output, IDX_W: high index of the current range.
- part_array, output, ARR_WIDTH*DATA_W: array handed to the partition stage; equals array_out.
- part_ready, input, 1: partition complete; sampled only in WAIT.
- part_array_in, input, ARR_WIDTH*DATA_W: partitioned array from the partition stage.
- part_pivot_idx, input, IDX_W: final pivot position returned by the partition stage.

Behaviour:
- Reset (asynchronous, reset=0): state=IDLE, stack pointer=0. All outputs are 0: busy, done, error, part_start, part_lo, part_hi, array_out.
- State machine: IDLE, INIT, POP, LAUNCH, WAIT, SPLIT, FINISH.
- IDLE:
  - On start=1: capture array_in into array_out, clear error, go to INIT.
  - start=0 holds IDLE.
  - start while busy is ignored.
- INIT: push (0, ARR_WIDTH-1), then go to POP.
- POP:
  - Stack empty: go to FINISH.
  - Otherwise pop the top into part_lo/part_hi.
  - If lo>=hi, stay in POP and pop the next entry; otherwise go to LAUNCH.
- LAUNCH: drive part_start=1 for exactly one cycle, then go to WAIT. part_lo, part_hi and part_array are held stable through WAIT.
- WAIT:
  - On part_ready=1: latch part_array_in into array_out and part_pivot_idx into p, then go to SPLIT.
  - A part_ready seen outside WAIT is ignored.
- SPLIT:
  - Arithmetic is done on IDX_W+1 bits, so no underflow when p=0.
  - left = (lo, p-1), pushed only if p >= lo+2.
  - right = (p+1, hi), pushed only if p+2 <= hi.
  - The larger sub-range is pushed first; ties push left first. This bounds depth to clog2(ARR_WIDTH)+1.
  - Up to two pushes take at most 2 cycles, then go to POP.
- Overflow: a push with the pointer at STACK_DEPTH sets error and goes to FINISH. The array is left as-is.
- FINISH: done=1 for one cycle, busy=0, go to IDLE. array_out holds until the next accepted start.
- Latency: sorted result in ≤ 3 + sum over partitions of (4 + partition latency) cycles.
- Simultaneous start and done: start is ignored because the FSM is not in IDLE.
- Reset mid-operation returns immediately to the reset values. The pending partition is abandoned, and part_start is not reissued.

Optional Feature:
- Macro QS_PART_TIMEOUT_EN.
- Defined: a counter is cleared on entry to WAIT and increments each WAIT cycle. Reaching TIMEOUT without part_ready sets error, drops the in-flight range, and goes to FINISH (done pulses).
- Undefined: no counter is built and WAIT waits indefinitely.

Test Plan:
- Bench partition model is Lomuto with a 3-cycle latency.
- Basic sort: array_in=16'h0213 (elements 3,1,2,0), pulse start -> done pulses once, array_out=16'h3210, error=0, busy falls the same cycle done rises.
- Already sorted: array_in=16'h3210 -> exactly 3 part_start pulses with (lo,hi)=(0,3),(0,2),(0,1), then array_out=16'h3210.
- All equal: array_in=16'h5555 -> array_out=16'h5555. No part_start is issued for a range with lo>=hi, and no overflow occurs.
- Handshake robustness:
  - start held high during busy -> no restart and a single done.
  - Spurious part_ready in LAUNCH -> ignored; the result is still correct.
- Reset mid-WAIT: assert reset=0 asynchronously -> busy, done, part_start and error read 0 within the same cycle. A following start with 16'h0213 sorts correctly.
- Timeout (QS_PART_TIMEOUT_EN, TIMEOUT=8): the model never asserts part_ready -> error=1 and done pulses 9 cycles after part_start.
